// File: rtl/step_sequencer_pkg.sv
// Shared constants and state encoding for the step sequencer slice.
package step_sequencer_pkg;

  localparam int unsigned DEF_WIDTH_TIME = 32;
  localparam int unsigned DEF_N_STAGES   = 350;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/step_sequencer_if.sv
// Stage-index / done handshake between tick source, sequencer and solver stages.
interface step_sequencer_if
  import step_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH_TIME = DEF_WIDTH_TIME,
  parameter int unsigned CNT_W      = 12
) ();

  logic                  run;
  logic                  step_tick;
  logic                  stage_ack;
  logic [WIDTH_TIME-1:0] stop_time;
  logic                  err_clr;
  logic [CNT_W-1:0]      counter;
  logic [WIDTH_TIME-1:0] sim_time;
  logic                  sta;
  logic                  busy;
  logic                  step_done;
  logic                  overrun;
  logic                  timeout_err;

  // Sequencer side: consumes ticks/acks, drives the stage index and status.
  modport master (
    input  run, step_tick, stage_ack, stop_time, err_clr,
    output counter, sim_time, sta, busy, step_done, overrun, timeout_err
  );

  // Environment side: tick source, stage array and status observer.
  modport slave (
    output run, step_tick, stage_ack, stop_time, err_clr,
    input  counter, sim_time, sta, busy, step_done, overrun, timeout_err
  );

endinterface

// File: rtl/step_sequencer_stage_watchdog.sv
// Per-stage dwell and timeout counters, both restarted by an advance strobe.
module stage_watchdog
  import step_sequencer_pkg::*;
#(
  parameter int unsigned MIN_DWELL = 2,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_ack_ok,
  output logic o_expire
);

  localparam int unsigned DW = (MIN_DWELL < 2) ? 1 : $clog2(MIN_DWELL + 1);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [DW-1:0] r_dwell;
  logic [TW-1:0] r_tmo;

  // Dwell counter: zero in the first cycle of a stage, saturates at MIN_DWELL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
    end else if (i_clr) begin
      r_dwell <= '0;
    end else if (r_dwell != DW'(MIN_DWELL)) begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // Timeout counter: zero in the first cycle of a stage, saturates at TIMEOUT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (i_clr) begin
      r_tmo <= '0;
    end else if (r_tmo != TW'(TIMEOUT - 1)) begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  // The current cycle counts toward the dwell/timeout, hence the +1.
  always_comb begin
    o_ack_ok = (32'(r_dwell) + 32'd1) >= MIN_DWELL;
    o_expire = (32'(r_tmo) + 32'd1) >= TIMEOUT;
  end

endmodule

// File: rtl/step_sequencer.sv
// Walks the stage index 1..N_STAGES once per real-time tick and tracks sim_time.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int unsigned N_STAGES   = DEF_N_STAGES,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned WIDTH_TIME = DEF_WIDTH_TIME,
  parameter int unsigned MIN_DWELL  = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic           clk,
  input  logic           sta_n,
  step_sequencer_if.master bus
);

  seq_state_t            r_state;
  seq_state_t            w_next_state;
  logic [CNT_W-1:0]      r_counter;
  logic [CNT_W-1:0]      w_next_counter;
  logic [WIDTH_TIME-1:0] r_sim_time;
  logic                  r_sta;
  logic                  r_busy;
  logic                  r_step_done;
  logic                  r_overrun;
  logic                  r_timeout_err;

  logic w_in_run;
  logic w_ack_ok;
  logic w_expire;
  logic w_accept;
  logic w_advance;
  logic w_tmo_set;
  logic w_start;
  logic w_ovr_set;
  logic w_wd_clr;
  logic w_last;

  stage_watchdog #(
    .MIN_DWELL (MIN_DWELL),
    .TIMEOUT   (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (sta_n),
    .i_clr    (w_wd_clr),
    .o_ack_ok (w_ack_ok),
    .o_expire (w_expire)
  );

  // Qualify acks/expiry and tick requests; an accepted ack masks a same-cycle expiry.
  always_comb begin
    w_in_run  = (r_state == ST_RUN);
    w_accept  = w_in_run && bus.stage_ack && w_ack_ok;
    w_advance = w_in_run && (w_accept || w_expire);
    w_tmo_set = w_in_run && w_expire && !w_accept;
    w_start   = (r_state == ST_IDLE) && bus.step_tick && bus.run &&
                (r_sim_time < bus.stop_time);
    w_ovr_set = (r_state != ST_IDLE) && bus.step_tick;
    w_wd_clr  = !w_in_run || w_advance;
    w_last    = (r_counter == CNT_W'(N_STAGES));
  end

  // Next-state and next stage index.
  always_comb begin
    w_next_state   = r_state;
    w_next_counter = r_counter;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next_state   = ST_CLEAR;
          w_next_counter = '0;
        end
      end
      ST_CLEAR: begin
        w_next_state   = ST_RUN;
        w_next_counter = CNT_W'(1);
      end
      ST_RUN: begin
        if (w_advance) begin
          if (w_last) begin
            w_next_state   = ST_DONE;
            w_next_counter = '0;
          end else begin
            w_next_counter = r_counter + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_next_state   = ST_IDLE;
        w_next_counter = '0;
      end
      default: begin
        w_next_state   = ST_IDLE;
        w_next_counter = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge sta_n) begin
    if (!sta_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge sta_n) begin
    if (!sta_n) begin
      r_counter   <= '0;
      r_sim_time  <= '0;
      r_sta       <= 1'b0;
      r_busy      <= 1'b0;
      r_step_done <= 1'b0;
    end else begin
      r_counter   <= w_next_counter;
      r_sta       <= (w_next_state == ST_CLEAR);
      r_busy      <= (w_next_state != ST_IDLE);
      r_step_done <= (w_next_state == ST_DONE);
      if (w_start && (r_sim_time != '1)) begin
        r_sim_time <= r_sim_time + WIDTH_TIME'(1);
      end
    end
  end

  // Sticky error flags; a set condition beats a same-cycle clear.
  always_ff @(posedge clk or negedge sta_n) begin
    if (!sta_n) begin
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (bus.err_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_tmo_set) begin
        r_timeout_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign bus.counter     = r_counter;
  assign bus.sim_time    = r_sim_time;
  assign bus.sta         = r_sta;
  assign bus.busy        = r_busy;
  assign bus.step_done   = r_step_done;
  assign bus.overrun     = r_overrun;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with a 4-stage, 16-cycle-timeout configuration.
module tb_step_sequencer;

  localparam int unsigned TWID = 16;
  localparam int unsigned CW   = 12;

  logic clk   = 1'b0;
  logic sta_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  step_sequencer_if #(.WIDTH_TIME(TWID), .CNT_W(CW)) bus ();

  step_sequencer #(
    .N_STAGES   (4),
    .CNT_W      (CW),
    .WIDTH_TIME (TWID),
    .MIN_DWELL  (2),
    .TIMEOUT    (16)
  ) dut (
    .clk   (clk),
    .sta_n (sta_n),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.step_tick = 1'b1;
    cyc();
    bus.step_tick = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.run = 1'b0; bus.step_tick = 1'b0; bus.stage_ack = 1'b0;
    bus.stop_time = '0; bus.err_clr = 1'b0;
    sta_n = 1'b0;
    #12;
    n_total++; if (bus.counter !== 12'd0) $display("FAIL reset_counter got %0d want 0", bus.counter); else n_pass++;
    n_total++; if (bus.sim_time !== 16'd0) $display("FAIL reset_sim_time got %0d want 0", bus.sim_time); else n_pass++;
    n_total++; if ({bus.sta, bus.busy, bus.step_done, bus.overrun, bus.timeout_err} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {bus.sta, bus.busy, bus.step_done, bus.overrun, bus.timeout_err}); else n_pass++;
    @(negedge clk);
    sta_n = 1'b1;
    cyc();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_basic();
    int exp_cnt [8] = '{1, 1, 2, 2, 3, 3, 4, 4};
    int busy_cnt;
    int done_cnt;
    int sta_cnt;
    bus.run = 1'b1; bus.stage_ack = 1'b1; bus.stop_time = 16'd10;
    tick();
    n_total++; if (bus.sta !== 1'b1) $display("FAIL basic_sta got %b want 1", bus.sta); else n_pass++;
    n_total++; if (bus.sim_time !== 16'd1) $display("FAIL basic_sim_time got %0d want 1", bus.sim_time); else n_pass++;
    n_total++; if (bus.counter !== 12'd0) $display("FAIL basic_clear_counter got %0d want 0", bus.counter); else n_pass++;
    busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
    done_cnt = (bus.step_done === 1'b1) ? 1 : 0;
    sta_cnt  = 1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_total++; if (bus.counter !== CW'(exp_cnt[i])) $display("FAIL basic_counter[%0d] got %0d want %0d", i, bus.counter, exp_cnt[i]); else n_pass++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.step_done === 1'b1) done_cnt++;
      if (bus.sta === 1'b1) sta_cnt++;
    end
    cyc();
    n_total++; if (bus.counter !== 12'd0) $display("FAIL basic_done_counter got %0d want 0", bus.counter); else n_pass++;
    n_total++; if (bus.step_done !== 1'b1) $display("FAIL basic_step_done got %b want 1", bus.step_done); else n_pass++;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.step_done === 1'b1) done_cnt++;
    cyc();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_end got %b want 0", bus.busy); else n_pass++;
    n_total++; if (busy_cnt != 10) $display("FAIL basic_busy_cycles got %0d want 10", busy_cnt); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL basic_done_pulses got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (sta_cnt != 1) $display("FAIL basic_sta_pulses got %0d want 1", sta_cnt); else n_pass++;
  endtask

  task automatic test_early_ack();
    bit ok;
    bus.stage_ack = 1'b0;
    tick();
    n_total++; if (bus.sim_time !== 16'd2) $display("FAIL early_sim_time got %0d want 2", bus.sim_time); else n_pass++;
    cyc();                        // counter=1, first cycle
    bus.stage_ack = 1'b1;
    cyc(); cyc();                 // ack accepted in second cycle of stage 1
    n_total++; if (bus.counter !== 12'd2) $display("FAIL early_reach2 got %0d want 2", bus.counter); else n_pass++;
    cyc();                        // ack in first cycle of stage 2 ignored
    bus.stage_ack = 1'b0;
    n_total++; if (bus.counter !== 12'd2) $display("FAIL early_ignored got %0d want 2", bus.counter); else n_pass++;
    cyc();
    n_total++; if (bus.counter !== 12'd2) $display("FAIL early_hold got %0d want 2", bus.counter); else n_pass++;
    bus.stage_ack = 1'b1;         // third cycle of stage 2
    cyc();
    n_total++; if (bus.counter !== 12'd3) $display("FAIL early_adv3 got %0d want 3", bus.counter); else n_pass++;
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL early_wait_idle got busy want idle"); else n_pass++;
    n_total++; if (bus.timeout_err !== 1'b0) $display("FAIL early_timeout_err got %b want 0", bus.timeout_err); else n_pass++;
  endtask

  task automatic test_watchdog();
    bit ok;
    bus.stage_ack = 1'b1;
    tick();
    for (int p = 1; p <= 37; p++) begin
      cyc();
      if (p == 5) begin
        n_total++; if (bus.counter !== 12'd3) $display("FAIL wd_stage3 got %0d want 3", bus.counter); else n_pass++;
        bus.stage_ack = 1'b0;
      end
      if (p == 20) begin
        n_total++; if (bus.counter !== 12'd3) $display("FAIL wd_before got %0d want 3", bus.counter); else n_pass++;
        n_total++; if (bus.timeout_err !== 1'b0) $display("FAIL wd_err_before got %b want 0", bus.timeout_err); else n_pass++;
      end
      if (p == 21) begin
        n_total++; if (bus.counter !== 12'd4) $display("FAIL wd_forced_adv got %0d want 4", bus.counter); else n_pass++;
        n_total++; if (bus.timeout_err !== 1'b1) $display("FAIL wd_err_set got %b want 1", bus.timeout_err); else n_pass++;
      end
      if (p == 25) begin
        n_total++; if (bus.timeout_err !== 1'b1) $display("FAIL wd_err_sticky got %b want 1", bus.timeout_err); else n_pass++;
        bus.err_clr = 1'b1;
      end
      if (p == 26) begin
        bus.err_clr = 1'b0;
        n_total++; if (bus.timeout_err !== 1'b0) $display("FAIL wd_err_clr got %b want 0", bus.timeout_err); else n_pass++;
      end
      if (p == 36) begin
        n_total++; if (bus.counter !== 12'd4) $display("FAIL wd_stage4_hold got %0d want 4", bus.counter); else n_pass++;
        bus.err_clr = 1'b1;
      end
      if (p == 37) begin
        bus.err_clr = 1'b0;
        n_total++; if (bus.timeout_err !== 1'b1) $display("FAIL wd_set_wins got %b want 1", bus.timeout_err); else n_pass++;
        n_total++; if (bus.step_done !== 1'b1) $display("FAIL wd_done got %b want 1", bus.step_done); else n_pass++;
      end
    end
    bus.stage_ack = 1'b1;
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL wd_wait_idle got busy want idle"); else n_pass++;
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
  endtask

  task automatic test_overrun();
    int done_cnt = 0;
    int sta_cnt  = 0;
    bit idle = 1'b0;
    bus.stage_ack = 1'b1;
    tick();
    n_total++; if (bus.sim_time !== 16'd4) $display("FAIL ovr_sim_time got %0d want 4", bus.sim_time); else n_pass++;
    cyc(); cyc(); cyc();
    n_total++; if (bus.counter !== 12'd2) $display("FAIL ovr_stage2 got %0d want 2", bus.counter); else n_pass++;
    bus.step_tick = 1'b1;
    cyc();
    bus.step_tick = 1'b0;
    n_total++; if (bus.overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", bus.overrun); else n_pass++;
    n_total++; if (bus.sim_time !== 16'd4) $display("FAIL ovr_sim_hold got %0d want 4", bus.sim_time); else n_pass++;
    for (int i = 0; i < 30 && !idle; i++) begin
      cyc();
      if (bus.step_done === 1'b1) done_cnt++;
      if (bus.sta === 1'b1) sta_cnt++;
      if (bus.busy === 1'b0) idle = 1'b1;
    end
    n_total++; if (!idle) $display("FAIL ovr_wait_idle got busy want idle"); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL ovr_done_pulses got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (sta_cnt != 0) $display("FAIL ovr_extra_sta got %0d want 0", sta_cnt); else n_pass++;
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
    n_total++; if (bus.overrun !== 1'b0) $display("FAIL ovr_clr got %b want 0", bus.overrun); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    bit ok;
    bus.stage_ack = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) cyc();
    n_total++; if (bus.counter !== 12'd3) $display("FAIL rmid_stage3 got %0d want 3", bus.counter); else n_pass++;
    #2;
    sta_n = 1'b0;
    #1;
    n_total++; if (bus.counter !== 12'd0) $display("FAIL rmid_counter got %0d want 0", bus.counter); else n_pass++;
    n_total++; if (bus.sim_time !== 16'd0) $display("FAIL rmid_sim_time got %0d want 0", bus.sim_time); else n_pass++;
    n_total++; if ({bus.sta, bus.busy, bus.step_done, bus.overrun, bus.timeout_err} !== 5'b0)
      $display("FAIL rmid_flags got %b want 00000", {bus.sta, bus.busy, bus.step_done, bus.overrun, bus.timeout_err}); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus.step_done === 1'b1) done_cnt++;
    end
    #3;
    sta_n = 1'b1;
    cyc();
    if (bus.step_done === 1'b1) done_cnt++;
    n_total++; if (done_cnt != 0) $display("FAIL rmid_no_done got %0d want 0", done_cnt); else n_pass++;
    tick();
    n_total++; if (bus.sim_time !== 16'd1) $display("FAIL rmid_restart_time got %0d want 1", bus.sim_time); else n_pass++;
    n_total++; if (bus.sta !== 1'b1) $display("FAIL rmid_restart_sta got %b want 1", bus.sta); else n_pass++;
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL rmid_wait_idle got busy want idle"); else n_pass++;
  endtask

  task automatic test_stop();
    int done_cnt = 0;
    bit ok;
    #2;
    sta_n = 1'b0;
    #2;
    sta_n = 1'b1;
    bus.stop_time = 16'd2; bus.run = 1'b1; bus.stage_ack = 1'b1;
    tick();
    n_total++; if (bus.sim_time !== 16'd1) $display("FAIL stop_t1 got %0d want 1", bus.sim_time); else n_pass++;
    wait_idle(ok);
    tick();
    n_total++; if (bus.sim_time !== 16'd2) $display("FAIL stop_t2 got %0d want 2", bus.sim_time); else n_pass++;
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL stop_wait_idle got busy want idle"); else n_pass++;
    tick();
    n_total++; if (bus.sta !== 1'b0) $display("FAIL stop_t3_sta got %b want 0", bus.sta); else n_pass++;
    n_total++; if (bus.sim_time !== 16'd2) $display("FAIL stop_t3_time got %0d want 2", bus.sim_time); else n_pass++;
    cyc();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL stop_t3_busy got %b want 0", bus.busy); else n_pass++;
    bus.stop_time = 16'd10; bus.run = 1'b0;
    tick();
    n_total++; if (bus.sta !== 1'b0) $display("FAIL norun_sta got %b want 0", bus.sta); else n_pass++;
    n_total++; if (bus.sim_time !== 16'd2) $display("FAIL norun_time got %0d want 2", bus.sim_time); else n_pass++;
    bus.run = 1'b1;
    tick();
    n_total++; if (bus.sim_time !== 16'd3) $display("FAIL run_t_time got %0d want 3", bus.sim_time); else n_pass++;
    cyc(); cyc();
    bus.run = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus.step_done === 1'b1) done_cnt++;
    end
    n_total++; if (done_cnt != 1) $display("FAIL run_drop_done got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL run_drop_idle got %b want 0", bus.busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_ack();
    test_watchdog();
    test_overrun();
    test_reset_mid();
    test_stop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
